axi4_lite_mul_responder: RTL and testbench

- AXI4-Lite slave (responder) exposing a byte-addressed register map: two SZ-bit operands and one 2*SZ-bit product.
- Sits on the slave side of the AXI4-Lite link and is driven by the existing master wrapper through the same AW/W/B/AR/R signal set.
- Computes the product with an iterative shift-add multiplier, one operand bit per cycle.
- Stalls product reads (holds arready low) while a multiplication is in flight.

---
 rtl/axi4_lite_mul_responder_if.sv | 37 +++
 rtl/axi4_lite_mul_responder.sv | 178 +++++++++++++++++
 tb/tb_axi4_lite_mul_responder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_mul_responder_if.sv
// AXI4-Lite channel bundle for the multiplier responder.
// Master drives requests, slave drives readies and responses.
interface axi4_lite_mul_responder_if #(
  parameter int ASZ = 4,
  parameter int DSZ = 8
);
  logic [ASZ-1:0] awaddr;
  logic           awvalid;
  logic           awready;
  logic [DSZ-1:0] wdata;
  logic           wvalid;
  logic           wready;
  logic           bresp;
  logic           bvalid;
  logic           bready;
  logic [ASZ-1:0] araddr;
  logic           arvalid;
  logic           arready;
  logic [DSZ-1:0] rdata;
  logic           rresp;
  logic           rvalid;
  logic           rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready,
    output araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready,
    input  araddr, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_mul_responder.sv
// AXI4-Lite responder: byte-mapped operands A, B and product P.
// Product computed by a shift-add multiplier, one bit per cycle.
module axi4_lite_mul_responder #(
  parameter int SZ  = 32,
  parameter int DSZ = 8,
  parameter int ASZ = 4
) (
  input  logic                        clk,
  input  logic                        _rst,
  axi4_lite_mul_responder_if.slave    bus,
  output logic                        busy
);
  localparam int K  = SZ / DSZ;
  localparam int CW = $clog2(SZ);

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic            rdy_q, rdy_d;
  logic            aw_held_q, aw_held_d;
  logic [ASZ-1:0]  aw_addr_q, aw_addr_d;
  logic            w_held_q, w_held_d;
  logic [DSZ-1:0]  w_data_q, w_data_d;
  logic            bvalid_q, bvalid_d;
  logic            bresp_q, bresp_d;
  logic            rvalid_q, rvalid_d;
  logic [DSZ-1:0]  rdata_q, rdata_d;
  logic            rresp_q, rresp_d;
  logic [SZ-1:0]   a_q, a_d;
  logic [SZ-1:0]   b_q, b_d;
  logic [2*SZ-1:0] p_q, p_d;
  logic [2*SZ-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            start;
  logic [31:0]     wa, ra;
  logic            p_hit;
  logic [4*SZ-1:0] regs;
  logic [2*SZ-1:0] addend;

  assign wa    = 32'(aw_addr_q);
  assign ra    = 32'(bus.araddr);
  assign p_hit = (ra >= 32'(2*K)) && (ra < 32'(4*K));
  assign regs  = {p_q, b_q, a_q};
  assign busy  = (state_q == RUN);

  assign bus.awready = rdy_q & ~aw_held_q & ~bvalid_q;
  assign bus.wready  = rdy_q & ~w_held_q & ~bvalid_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = rdy_q & ~rvalid_q & ~(p_hit & busy);
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

  // Channel handshakes, register writes and multiplier stepping.
  always_comb begin
    state_d   = state_q;
    rdy_d     = 1'b1;
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    a_d       = a_q;
    b_d       = b_q;
    p_d       = p_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    start     = 1'b0;
    addend    = '0;

    if (bus.awvalid && bus.awready) begin
      aw_held_d = 1'b1;
      aw_addr_d = bus.awaddr;
    end
    if (bus.wvalid && bus.wready) begin
      w_held_d = 1'b1;
      w_data_d = bus.wdata;
    end

    if (bvalid_q && bus.bready) begin
      bvalid_d = 1'b0;
      bresp_d  = 1'b0;
    end else if (aw_held_q && w_held_q && !bvalid_q) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (wa < 32'(K)) begin
        a_d[wa*DSZ +: DSZ] = w_data_q;
        bresp_d = 1'b1;
        start   = 1'b1;
      end else if (wa < 32'(2*K)) begin
        b_d[(wa-32'(K))*DSZ +: DSZ] = w_data_q;
        bresp_d = 1'b1;
        start   = 1'b1;
      end else begin
        bresp_d = 1'b0;
      end
    end

    if (rvalid_q && bus.rready) begin
      rvalid_d = 1'b0;
    end else if (bus.arvalid && bus.arready) begin
      rvalid_d = 1'b1;
      if (ra < 32'(4*K)) begin
        rdata_d = regs[ra*DSZ +: DSZ];
        rresp_d = 1'b1;
      end else begin
        rdata_d = '0;
        rresp_d = 1'b0;
      end
    end

    unique case (state_q)
      IDLE: ;
      RUN: begin
        if (a_q[cnt_q]) addend = {{SZ{1'b0}}, b_q} << cnt_q;
        acc_d = acc_q + addend;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(SZ-1)) begin
          p_d     = acc_d;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = RUN;
      cnt_d   = '0;
      acc_d   = '0;
    end
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q   <= IDLE;
      rdy_q     <= 1'b0;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= rdy_d;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      a_q       <= a_d;
      b_q       <= b_d;
      p_q       <= p_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_axi4_lite_mul_responder.sv
// Bench for axi4_lite_mul_responder: directed writes/reads,
// expected responses queued and checked by a bus monitor.
module tb_axi4_lite_mul_responder;
  localparam int SZ  = 32;
  localparam int DSZ = 8;
  localparam int ASZ = 4;

  logic clk  = 1'b0;
  logic _rst = 1'b1;
  logic busy;

  axi4_lite_mul_responder_if #(.ASZ(ASZ), .DSZ(DSZ)) bus ();

  axi4_lite_mul_responder #(.SZ(SZ), .DSZ(DSZ), .ASZ(ASZ)) dut (
    .clk  (clk),
    ._rst (_rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic       exp_b[$];
  logic [8:0] exp_r[$];

  logic bv_prev = 1'b0;
  int   run_len = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // Scoreboard monitor: pop expectations on each completed response.
  always @(negedge clk) begin
    if (_rst) begin
      if (bus.bvalid && bus.bready) begin
        if (exp_b.size() == 0) tmo("unexpected_bresp");
        else chk("bresp", 64'(bus.bresp), 64'(exp_b.pop_front()));
      end
      if (bus.rvalid && bus.rready) begin
        if (exp_r.size() == 0) tmo("unexpected_rdata");
        else chk("rresp_rdata", 64'({bus.rresp, bus.rdata}),
                 64'(exp_r.pop_front()));
      end
    end
  end

  // Busy length measured from the most recent bvalid rise.
  always @(negedge clk) begin
    if (bus.bvalid && !bv_prev) run_len = 0;
    if (busy) run_len++;
    bv_prev = bus.bvalid;
  end

  task automatic wr(input logic [ASZ-1:0] a, input logic [DSZ-1:0] d,
                    input logic eb);
    int n;
    logic ah, wh, ad, wd;
    exp_b.push_back(eb);
    @(negedge clk);
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wvalid = 1'b1; bus.bready = 1'b1;
    #1;
    ad = 1'b0; wd = 1'b0; n = 0;
    while (!(ad && wd) && n < 50) begin
      ah = bus.awvalid && bus.awready;
      wh = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      if (ah) begin bus.awvalid = 1'b0; ad = 1'b1; end
      if (wh) begin bus.wvalid = 1'b0; wd = 1'b1; end
      @(negedge clk);
      n++;
    end
    if (!(ad && wd)) tmo("write_addr_data");
    n = 0;
    while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bus.bvalid) tmo("write_bvalid");
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [ASZ-1:0] a, input logic [DSZ-1:0] d,
                    input logic er);
    int n;
    exp_r.push_back({er, d});
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    #1;
    n = 0;
    while (!bus.arready && n < 200) begin @(negedge clk); n++; end
    if (!bus.arready) tmo("read_arready");
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    @(negedge clk);
    if (!bus.rvalid) tmo("read_rvalid");
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    if (busy) tmo("wait_idle");
  endtask

  task automatic chk_zero(input string name);
    chk(name, 64'({bus.awready, bus.wready, bus.bresp, bus.bvalid,
                   bus.arready, bus.rdata, bus.rresp, bus.rvalid, busy}),
        64'(0));
  endtask

  initial begin
    logic [7:0] pa[8];
    logic [7:0] pf[8];
    pa = '{8'hBC, 8'h62, 8'h58, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    pf = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
    bus.awaddr = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    #2 _rst = 1'b0;
    #10;
    chk_zero("reset_outputs");
    @(negedge clk);
    _rst = 1'b1;
    #1;
    chk("ready_before_edge", 64'({bus.awready, bus.wready, bus.arready}), 0);
    @(negedge clk);
    chk("ready_after_edge", 64'({bus.awready, bus.wready, bus.arready}), 7);

    // 10234 * 566
    wr(0, 8'hFA, 1); wr(1, 8'h27, 1); wr(2, 8'h00, 1); wr(3, 8'h00, 1);
    wr(4, 8'h36, 1); wr(5, 8'h02, 1); wr(6, 8'h00, 1); wr(7, 8'h00, 1);
    wait_idle();
    for (int i = 0; i < 8; i++) rd(ASZ'(8 + i), pa[i], 1'b1);

    // all-ones operands
    for (int i = 0; i < 8; i++) wr(ASZ'(i), 8'hFF, 1'b1);
    wait_idle();
    chk("busy_len_ones", 64'(run_len), 64'(32));
    for (int i = 0; i < 8; i++) rd(ASZ'(8 + i), pf[i], 1'b1);

    // W three cycles ahead of AW, bready stalled
    exp_b.push_back(1'b1);
    @(negedge clk);
    bus.wdata = 8'h03; bus.wvalid = 1'b1;
    bus.awaddr = 4'd0; bus.bready = 1'b0;
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
    @(negedge clk);
    chk("wready_drop", 64'({bus.wready, bus.awready}), 64'(1));
    repeat (2) @(negedge clk);
    bus.awvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bvalid_hold", 64'({bus.bvalid, bus.bresp, bus.awready,
                              bus.wready}), 64'(4'b1100));
    end
    @(posedge clk); #1;
    bus.bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("readies_back", 64'({bus.bvalid, bus.awready, bus.wready}),
        64'(3'b011));
    wait_idle();

    // A=5, B=FFFFFFFF; product read stalls while busy
    wr(1, 8'h00, 1); wr(2, 8'h00, 1); wr(3, 8'h00, 1);
    wr(0, 8'h05, 1);
    @(negedge clk);
    bus.araddr = 4'd8; bus.arvalid = 1'b1; bus.rready = 1'b1;
    #1;
    chk("ar_stall", 64'({busy, bus.arready}), 64'(2'b10));
    rd(8, 8'hFB, 1);
    rd(9, 8'hFF, 1);
    rd(12, 8'h04, 1);
    wr(1, 8'h00, 1);
    rd(0, 8'h05, 1);
    chk("busy_during_a_read", 64'(busy), 64'(1));
    wait_idle();

    // write to product address is rejected
    wr(9, 8'h55, 0);
    @(negedge clk);
    chk("no_restart", 64'(busy), 64'(0));
    rd(8, 8'hFB, 1);
    rd(9, 8'hFF, 1);

    // restart mid-run with new A
    wr(4, 8'h34, 1); wr(5, 8'h12, 1); wr(6, 8'h00, 1); wr(7, 8'h00, 1);
    wait_idle();
    wr(0, 8'h07, 1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("mid_run_busy", 64'(busy), 64'(1));
    wr(0, 8'h0B, 1);
    wait_idle();
    chk("busy_len_restart", 64'(run_len), 64'(32));
    rd(8, 8'h3C, 1);
    rd(9, 8'hC8, 1);
    rd(10, 8'h00, 1);

    // reset during a run
    wr(0, 8'h01, 1);
    repeat (5) @(negedge clk);
    _rst = 1'b0;
    #1;
    chk_zero("async_reset_outputs");
    @(negedge clk);
    chk_zero("held_reset_outputs");
    _rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) rd(ASZ'(i), 8'h00, 1'b1);

    repeat (3) @(negedge clk);
    if (exp_b.size() != 0 || exp_r.size() != 0) tmo("scoreboard_drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
